// File: rtl/lb_region_dispatcher.sv
// -----------------------------------------------------------------------------
// lb_region_dispatcher
//
// Purpose:
//   Front end of the load balancer. HTTP request metadata is buffered in a
//   small in-order FIFO. The operator ID of the request at the head of the FIFO
//   is compared with the operator loaded in every reconfigurable region.
//     - If an idle region holds it, a dispatch command is issued to the
//       lowest-index such region.
//     - If a region holds it but every such region is busy, the head waits.
//     - If no region holds it and PR_EN=1, a reconfiguration request is
//       issued for a round-robin victim region. The dispatcher then waits for
//       pr_done and retries the same entry against the updated region table.
//     - If no region holds it and PR_EN=0, the entry is dropped and counted.
//   Requests are served strictly in order. A waiting head blocks all entries
//   behind it.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   meta_tvalid/tready/tdata
//                      request metadata stream into the FIFO
//   region_stats_in    one W-bit slot per region: the operator currently loaded
//   region_busy        one bit per region: 1 = region occupied
//   lb_ctrl_valid/ready/lb_ctrl
//                      dispatch command {region index, operator ID}
//   pr_ctrl_valid/ready/pr_ctrl
//                      reconfiguration request {victim index, operator ID}
//   pr_done            one-cycle pulse: reconfiguration finished
//   queue_level        FIFO occupancy, 0..QDEPTH
//   drop_cnt           saturating count of dropped misses
// -----------------------------------------------------------------------------
module lb_region_dispatcher #(
    parameter int OPERATOR_ID_WIDTH = 16,
    parameter int HTTP_META_WIDTH   = 8,
    parameter int N_REGIONS         = 4,
    parameter int QDEPTH            = 4,
    parameter int PR_EN             = 1
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   meta_tvalid,
    output logic                                   meta_tready,
    input  logic [HTTP_META_WIDTH-1:0]             meta_tdata,
    input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_stats_in,
    input  logic [N_REGIONS-1:0]                   region_busy,
    output logic                                   lb_ctrl_valid,
    input  logic                                   lb_ctrl_ready,
    output logic [2*OPERATOR_ID_WIDTH-1:0]         lb_ctrl,
    output logic                                   pr_ctrl_valid,
    input  logic                                   pr_ctrl_ready,
    output logic [2*OPERATOR_ID_WIDTH-1:0]         pr_ctrl,
    input  logic                                   pr_done,
    output logic [$clog2(QDEPTH):0]                queue_level,
    output logic [31:0]                            drop_cnt
);

    localparam int W    = OPERATOR_ID_WIDTH;
    localparam int IDXW = $clog2(N_REGIONS);
    localparam int PTRW = $clog2(QDEPTH);
    localparam int CNTW = PTRW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DISPATCH,
        S_PR_REQ,
        S_PR_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            state_reg,   state_next;
    logic [PTRW-1:0]   wr_ptr_reg;
    logic [PTRW-1:0]   rd_ptr_reg,  rd_ptr_next;
    logic [CNTW-1:0]   count_reg;
    logic [W-1:0]      head_op_reg;
    logic [W-1:0]      mem_reg [QDEPTH];
    logic [2*W-1:0]    lb_ctrl_reg, lb_ctrl_next;
    logic [2*W-1:0]    pr_ctrl_reg, pr_ctrl_next;
    logic [IDXW-1:0]   victim_reg,  victim_next;
    logic [IDXW-1:0]   rr_ptr_reg,  rr_ptr_next;
    logic [31:0]       drop_cnt_reg, drop_cnt_next;
    logic              ready_en_reg;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [W-1:0]          op_in;
    logic                  push;
    logic                  pop;
    logic [N_REGIONS-1:0]  match_vec;
    logic [N_REGIONS-1:0]  avail_vec;
    logic                  any_match;
    logic                  hit_found;
    logic [IDXW-1:0]       hit_idx;
    logic                  victim_found;
    logic [IDXW-1:0]       victim_idx;
    logic                  more_pending;

    // Zero-extend or truncate the metadata to operator-ID width.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_op
            if (gi < HTTP_META_WIDTH) begin : g_copy
                assign op_in[gi] = meta_tdata[gi];
            end else begin : g_zero
                assign op_in[gi] = 1'b0;
            end
        end
    endgenerate

    // Per-region comparison of the head operator against the loaded one.
    generate
        for (gi = 0; gi < N_REGIONS; gi++) begin : g_match
            assign match_vec[gi] = (region_stats_in[gi*W +: W] == head_op_reg);
            assign avail_vec[gi] = match_vec[gi] & ~region_busy[gi];
        end
    endgenerate

    assign any_match = |match_vec;

    // Region index placed in the low bits of a W-bit field, upper bits zero.
    function automatic logic [W-1:0] idx_ext(input logic [IDXW-1:0] idx);
        logic [W-1:0] ext;
        ext            = '0;
        ext[IDXW-1:0]  = idx;
        return ext;
    endfunction

    // Lowest-index idle region that already holds the operator.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (avail_vec[i]) begin
                hit_found = 1'b1;
                hit_idx   = IDXW'(i);
            end
        end
    end

    // First idle region starting at rr_ptr and wrapping modulo N_REGIONS.
    // The loop runs downward so the smallest offset from rr_ptr wins.
    // N_REGIONS need not be a power of two, so the wrap is an explicit subtract.
    always_comb begin
        logic [IDXW:0] cand;
        victim_found = 1'b0;
        victim_idx   = '0;
        cand         = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_reg} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(N_REGIONS)) begin
                cand = cand - (IDXW+1)'(N_REGIONS);
            end
            if (!region_busy[cand[IDXW-1:0]]) begin
                victim_found = 1'b1;
                victim_idx   = cand[IDXW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Ready is held low until the first clock edge after reset release.
    assign meta_tready = ready_en_reg && (count_reg < CNTW'(QDEPTH));
    assign push        = meta_tvalid && meta_tready;
    assign rd_ptr_next = rd_ptr_reg + PTRW'(pop);
    assign more_pending = (count_reg > CNTW'(1));

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= op_in;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_op_reg  <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
            // The head is read one edge ahead, from the next read address. When
            // that address is written in the same cycle, the FIFO is empty,
            // so the incoming word is forwarded directly.
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_op_reg <= op_in;
            end else begin
                head_op_reg <= mem_reg[rd_ptr_next];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= S_IDLE;
            lb_ctrl_reg  <= '0;
            pr_ctrl_reg  <= '0;
            victim_reg   <= '0;
            rr_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lb_ctrl_reg  <= lb_ctrl_next;
            pr_ctrl_reg  <= pr_ctrl_next;
            victim_reg   <= victim_next;
            rr_ptr_reg   <= rr_ptr_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pop           = 1'b0;
        lb_ctrl_next  = lb_ctrl_reg;
        pr_ctrl_next  = pr_ctrl_reg;
        victim_next   = victim_reg;
        rr_ptr_next   = rr_ptr_reg;
        drop_cnt_next = drop_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    state_next = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit_found) begin
                    lb_ctrl_next = {idx_ext(hit_idx), head_op_reg};
                    state_next   = S_DISPATCH;
                end else if (any_match) begin
                    // Operator is loaded but every holder is busy: keep polling.
                    state_next = S_LOOKUP;
                end else if (PR_EN != 0) begin
                    if (victim_found) begin
                        pr_ctrl_next = {idx_ext(victim_idx), head_op_reg};
                        victim_next  = victim_idx;
                        state_next   = S_PR_REQ;
                    end
                end else begin
                    pop = 1'b1;
                    if (drop_cnt_reg != 32'hFFFF_FFFF) begin
                        drop_cnt_next = drop_cnt_reg + 32'd1;
                    end
                    state_next = more_pending ? S_LOOKUP : S_IDLE;
                end
            end

            S_DISPATCH: begin
                if (lb_ctrl_ready) begin
                    pop        = 1'b1;
                    state_next = more_pending ? S_LOOKUP : S_IDLE;
                end
            end

            S_PR_REQ: begin
                if (pr_ctrl_ready) begin
                    if (victim_reg == IDXW'(N_REGIONS - 1)) begin
                        rr_ptr_next = '0;
                    end else begin
                        rr_ptr_next = victim_reg + IDXW'(1);
                    end
                    state_next = S_PR_WAIT;
                end
            end

            S_PR_WAIT: begin
                // The entry stays at the head and is looked up again once the
                // region table reflects the new operator.
                if (pr_done) begin
                    state_next = S_LOOKUP;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lb_ctrl_valid = (state_reg == S_DISPATCH);
    assign pr_ctrl_valid = (state_reg == S_PR_REQ);
    assign lb_ctrl       = lb_ctrl_reg;
    assign pr_ctrl       = pr_ctrl_reg;
    assign queue_level   = count_reg;
    assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_lb_region_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_lb_region_dispatcher
//
// Two instances share clock, reset, metadata, region table and busy vector:
//   dut  : PR_EN=1 (dispatch + partial reconfiguration)
//   dutb : PR_EN=0 (misses are dropped and counted)
// Expected results come from a small table model of the regions plus a
// round-robin pointer kept in the bench.
// -----------------------------------------------------------------------------
module tb_lb_region_dispatcher;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] meta_tdata = '0;
    logic [63:0] region_stats_in;
    logic [3:0]  region_busy = '0;

    // PR_EN=1 instance
    logic        meta_tvalid = 1'b0;
    logic        meta_tready;
    logic        lb_ctrl_valid;
    logic        lb_ctrl_ready = 1'b0;
    logic [31:0] lb_ctrl;
    logic        pr_ctrl_valid;
    logic        pr_ctrl_ready = 1'b0;
    logic [31:0] pr_ctrl;
    logic        pr_done = 1'b0;
    logic [2:0]  queue_level;
    logic [31:0] drop_cnt;

    // PR_EN=0 instance
    logic        b_tvalid = 1'b0;
    logic        b_tready;
    logic        b_lb_valid;
    logic        b_lb_ready = 1'b1;
    logic [31:0] b_lb_ctrl;
    logic        b_pr_valid;
    logic        b_pr_ready = 1'b0;
    logic [31:0] b_pr_ctrl;
    logic        b_pr_done = 1'b0;
    logic [2:0]  b_level;
    logic [31:0] b_drop_cnt;

    logic [15:0] stats_m [4];
    int          rr_m = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always_comb region_stats_in = {stats_m[3], stats_m[2], stats_m[1], stats_m[0]};

    always #5 aclk = ~aclk;

    lb_region_dispatcher #(
        .OPERATOR_ID_WIDTH(16), .HTTP_META_WIDTH(16), .N_REGIONS(4), .QDEPTH(4), .PR_EN(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .meta_tvalid(meta_tvalid), .meta_tready(meta_tready), .meta_tdata(meta_tdata),
        .region_stats_in(region_stats_in), .region_busy(region_busy),
        .lb_ctrl_valid(lb_ctrl_valid), .lb_ctrl_ready(lb_ctrl_ready), .lb_ctrl(lb_ctrl),
        .pr_ctrl_valid(pr_ctrl_valid), .pr_ctrl_ready(pr_ctrl_ready), .pr_ctrl(pr_ctrl),
        .pr_done(pr_done), .queue_level(queue_level), .drop_cnt(drop_cnt)
    );

    lb_region_dispatcher #(
        .OPERATOR_ID_WIDTH(16), .HTTP_META_WIDTH(16), .N_REGIONS(4), .QDEPTH(4), .PR_EN(0)
    ) dutb (
        .aclk(aclk), .aresetn(aresetn),
        .meta_tvalid(b_tvalid), .meta_tready(b_tready), .meta_tdata(meta_tdata),
        .region_stats_in(region_stats_in), .region_busy(region_busy),
        .lb_ctrl_valid(b_lb_valid), .lb_ctrl_ready(b_lb_ready), .lb_ctrl(b_lb_ctrl),
        .pr_ctrl_valid(b_pr_valid), .pr_ctrl_ready(b_pr_ready), .pr_ctrl(b_pr_ctrl),
        .pr_done(b_pr_done), .queue_level(b_level), .drop_cnt(b_drop_cnt)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: which region should serve op, given table, busy and rr pointer.
    // kind 0 = dispatch to returned region, 2 = reconfigure returned region,
    // 1 = nothing can happen yet.
    function automatic int model_pick(input logic [15:0] op, input logic [3:0] busy,
                                      input int rr, output int kind);
        bit held;
        held = 1'b0;
        kind = 1;
        for (int r = 0; r < 4; r++) if (stats_m[r] == op) held = 1'b1;
        if (held) begin
            for (int r = 0; r < 4; r++) begin
                if (stats_m[r] == op && !busy[r]) begin
                    kind = 0;
                    return r;
                end
            end
            return -1;
        end
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (rr + i) % 4;
            if (!busy[v]) begin
                kind = 2;
                return v;
            end
        end
        return -1;
    endfunction

    task automatic push_a(input logic [15:0] d);
        meta_tvalid = 1'b1;
        meta_tdata  = d;
        step();
        meta_tvalid = 1'b0;
    endtask

    task automatic wait_lb(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!lb_ctrl_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, lb_ctrl_valid, 1);
        check(tag, lb_ctrl, exp);
        lb_ctrl_ready = 1'b1;
        step();
        lb_ctrl_ready = 1'b0;
    endtask

    task automatic wait_pr(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!pr_ctrl_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, pr_ctrl_valid, 1);
        check(tag, pr_ctrl, exp);
        pr_ctrl_ready = 1'b1;
        step();
        pr_ctrl_ready = 1'b0;
    endtask

    task automatic pulse_done();
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
    endtask

    // No command of either instance may appear for n cycles.
    task automatic expect_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            seen = seen | lb_ctrl_valid | pr_ctrl_valid | b_lb_valid | b_pr_valid;
            step();
        end
        check(tag, seen, 0);
    endtask

    task automatic set_default_stats();
        stats_m[0] = 16'h0001;
        stats_m[1] = 16'h0002;
        stats_m[2] = 16'h0003;
        stats_m[3] = 16'h0004;
    endtask

    // ------------------------------------------------------------------
    // Directed + randomised sequence
    // ------------------------------------------------------------------
    logic [15:0] full_vals [5];
    logic [15:0] exp_q [$];
    int          acc;
    int          kind;
    int          r;
    int          guard;
    bit          done;
    logic [15:0] op;
    logic        seen_b;

    initial begin
        set_default_stats();
        full_vals[0] = 16'h0001;
        full_vals[1] = 16'h0002;
        full_vals[2] = 16'h0003;
        full_vals[3] = 16'h0004;
        full_vals[4] = 16'h0001;

        // ---- reset state ----
        aresetn = 1'b0;
        step();
        step();
        check("rst_lb_valid", lb_ctrl_valid, 0);
        check("rst_pr_valid", pr_ctrl_valid, 0);
        check("rst_lb_ctrl", lb_ctrl, 0);
        check("rst_level", queue_level, 0);
        check("rst_tready", meta_tready, 0);
        check("rst_drop", b_drop_cnt, 0);
        aresetn = 1'b1;
        step();
        check("post_rst_tready", meta_tready, 1);

        // ---- single hit, latency ----
        push_a(16'h0003);
        check("hit_lat_k", lb_ctrl_valid, 0);
        step();
        check("hit_lat_k1", lb_ctrl_valid, 0);
        step();
        check("hit_lat_k2", lb_ctrl_valid, 1);
        check("hit_ctrl", lb_ctrl, 32'h0002_0003);
        lb_ctrl_ready = 1'b1;
        step();
        lb_ctrl_ready = 1'b0;
        check("hit_level_after", queue_level, 0);

        // ---- FIFO full ----
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            meta_tvalid = 1'b1;
            meta_tdata  = full_vals[i];
            if (meta_tready) begin
                acc++;
                exp_q.push_back(full_vals[i]);
            end
            step();
        end
        meta_tvalid = 1'b0;
        check("full_accepted", acc, 4);
        check("full_tready", meta_tready, 0);
        check("full_level", queue_level, 4);
        op = exp_q.pop_front();
        r = model_pick(op, region_busy, rr_m, kind);
        wait_lb("full_first", {16'(r), op});
        check("full_level_after", queue_level, 3);
        check("full_tready_after", meta_tready, 1);
        while (exp_q.size() > 0) begin
            op = exp_q.pop_front();
            r = model_pick(op, region_busy, rr_m, kind);
            wait_lb("full_drain", {16'(r), op});
        end
        check("full_drained", queue_level, 0);

        // ---- matching region busy ----
        region_busy = 4'b0001;
        push_a(16'h0001);
        expect_quiet("busy_quiet", 6);
        region_busy = 4'b0000;
        wait_lb("busy_release", 32'h0000_0001);

        // ---- partial reconfiguration ----
        region_busy = 4'b0001;
        push_a(16'h00AA);
        wait_pr("pr_req", 32'h0001_00AA);
        rr_m = 2;
        expect_quiet("pr_wait_quiet", 4);
        check("pr_wait_level", queue_level, 1);
        stats_m[1] = 16'h00AA;
        region_busy = 4'b0000;
        pulse_done();
        wait_lb("pr_dispatch", 32'h0001_00AA);

        // ---- randomised requests against the table model ----
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) != 0) op = stats_m[$urandom_range(0, 3)];
            else op = 16'($urandom);
            region_busy = 4'($urandom);
            push_a(op);
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 6) begin
                r = model_pick(op, region_busy, rr_m, kind);
                if (kind == 0) begin
                    wait_lb("rnd_hit", {16'(r), op});
                    done = 1'b1;
                end else if (kind == 2) begin
                    wait_pr("rnd_pr", {16'(r), op});
                    rr_m = (r + 1) % 4;
                    stats_m[r] = op;
                    step();
                    pulse_done();
                end else begin
                    expect_quiet("rnd_stall", 4);
                    region_busy = 4'b0000;
                end
                guard++;
            end
            check("rnd_level", queue_level, 0);
        end

        // ---- reset while waiting for reconfiguration ----
        set_default_stats();
        region_busy = 4'b1101;
        step();
        push_a(16'h0BEE);
        r = model_pick(16'h0BEE, region_busy, rr_m, kind);
        check("rpr_model_victim", r, 1);
        wait_pr("rpr_req", 32'h0001_0BEE);
        step();
        #3;
        aresetn = 1'b0;
        #1;
        check("rpr_lb_valid", lb_ctrl_valid, 0);
        check("rpr_pr_valid", pr_ctrl_valid, 0);
        check("rpr_pr_ctrl", pr_ctrl, 0);
        check("rpr_lb_ctrl", lb_ctrl, 0);
        check("rpr_level", queue_level, 0);
        check("rpr_tready", meta_tready, 0);
        step();
        aresetn = 1'b1;
        rr_m = 0;
        region_busy = 4'b0000;
        step();
        check("rpr_tready_back", meta_tready, 1);
        push_a(16'h0CDE);
        r = model_pick(16'h0CDE, region_busy, rr_m, kind);
        wait_pr("rpr_victim0", {16'(r), 16'h0CDE});
        check("rpr_victim_const", pr_ctrl, 32'h0000_0CDE);
        rr_m = (r + 1) % 4;
        stats_m[r] = 16'h0CDE;
        step();
        pulse_done();
        wait_lb("rpr_dispatch", 32'h0000_0CDE);

        // ---- PR_EN=0 instance: drop and hit ----
        set_default_stats();
        step();
        b_tvalid   = 1'b1;
        meta_tdata = 16'h00AA;
        step();
        b_tvalid   = 1'b0;
        expect_quiet("drop_quiet", 6);
        check("drop_cnt1", b_drop_cnt, 1);
        check("drop_level", b_level, 0);
        b_tvalid   = 1'b1;
        meta_tdata = 16'h0002;
        step();
        b_tvalid   = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 20 && !seen_b; i++) begin
            if (b_lb_valid) begin
                seen_b = 1'b1;
                check("b_hit_ctrl", b_lb_ctrl, 32'h0001_0002);
            end
            step();
        end
        check("b_hit_seen", seen_b, 1);
        b_tvalid   = 1'b1;
        meta_tdata = 16'h0077;
        step();
        b_tvalid   = 1'b0;
        expect_quiet("drop2_quiet", 6);
        check("drop_cnt2", b_drop_cnt, 2);
        check("b_pr_never", b_pr_ctrl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, assertions %0d failures %0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
